// File: rtl/kyber_pkg.sv
// Shared ML-KEM-768 decapsulation types and sizes.
// Used by the compare/select stage and later decaps stages.
package kyber_pkg;

  localparam int KYBER_C_BYTES  = 1088;
  localparam int KYBER_SS_BYTES = 32;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    SEL  = 2'd2,
    DONE = 2'd3
  } cmp_state_e;

endpackage

// File: rtl/kpke_ct_compare_select_if.sv
// Byte stream of the re-encrypted ciphertext c'.
// Plain valid/ready handshake, one byte per beat.
interface kpke_ct_compare_select_if;
  import kyber_pkg::*;

  logic  cp_valid;
  byte_t cp_data;
  logic  cp_ready;

  modport master (
    output cp_valid,
    output cp_data,
    input  cp_ready
  );

  modport slave (
    input  cp_valid,
    input  cp_data,
    output cp_ready
  );

endinterface

// File: rtl/ct_mask_select.sv
// Constant-time byte-array select: y = (a & mask) | (b & ~mask).
// No mux select on data; every byte goes through the same AND/OR.
module ct_mask_select
  import kyber_pkg::*;
#(
  parameter int N = KYBER_SS_BYTES
) (
  input  byte_t i_a [N],
  input  byte_t i_b [N],
  input  byte_t i_mask,
  output byte_t o_y [N]
);

  // Bitwise blend of both candidates under the same mask.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      o_y[i] = (i_a[i] & i_mask) | (i_b[i] & ~i_mask);
    end
  end

endmodule

// File: rtl/kpke_ct_compare_select.sv
// Streams c' against c, OR-accumulates differences, then picks
// K' or K_bar with a mask; timing never depends on the data.
module kpke_ct_compare_select
  import kyber_pkg::*;
#(
  parameter int C_BYTES  = KYBER_C_BYTES,
  parameter int SS_BYTES = KYBER_SS_BYTES
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  byte_t c       [C_BYTES],
  input  byte_t k_prime [SS_BYTES],
  input  byte_t k_bar   [SS_BYTES],
  kpke_ct_compare_select_if.slave cp,
  output logic  busy,
  output logic  done,
  output logic  match,
  output byte_t k_out   [SS_BYTES]
);

  localparam int IW = $clog2(C_BYTES);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CMP  = CMP;
  localparam logic [1:0] ST_SEL  = SEL;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [IW-1:0] LAST = IW'(C_BYTES - 1);

  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  byte_t         r_diff;
  logic          r_match;
  byte_t         r_k_out [SS_BYTES];

  logic  w_ready;
  logic  w_beat;
  logic  w_eq;
  byte_t w_mask;
  byte_t w_sel [SS_BYTES];

  assign w_ready = (r_state == ST_CMP);
  assign w_beat  = cp.cp_valid & w_ready;

  // Full reduction of diff; only consumed in SEL.
  assign w_eq   = (r_diff == 8'h00);
  assign w_mask = {8{w_eq}};

  ct_mask_select #(
    .N (SS_BYTES)
  ) u_sel (
    .i_a    (k_prime),
    .i_b    (k_bar),
    .i_mask (w_mask),
    .o_y    (w_sel)
  );

  // FSM, byte index, difference accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_diff  <= '0;
      r_match <= 1'b0;
      for (int i = 0; i < SS_BYTES; i++) r_k_out[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_CMP;
            r_idx   <= '0;
            r_diff  <= '0;
            r_match <= 1'b0;
            for (int i = 0; i < SS_BYTES; i++) r_k_out[i] <= '0;
          end
        end
        ST_CMP: begin
          if (w_beat) begin
            r_diff <= r_diff | (c[r_idx] ^ cp.cp_data);
            if (r_idx == LAST) begin
              r_state <= ST_SEL;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        ST_SEL: begin
          r_k_out <= w_sel;
          r_match <= w_eq;
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cp.cp_ready = w_ready;
  assign busy        = (r_state == ST_CMP) | (r_state == ST_SEL);
  assign done        = (r_state == ST_DONE);
  assign match       = r_match;
  assign k_out       = r_k_out;

endmodule

// File: tb/tb_kpke_ct_compare_select.sv
// Directed-vector bench for the ciphertext compare/select stage.
// Latency is counted in clock edges from the start edge to the edge that samples done.
module tb_kpke_ct_compare_select;
  import kyber_pkg::*;

  localparam int CB = KYBER_C_BYTES;
  localparam int SB = KYBER_SS_BYTES;

  typedef struct {
    string name;
    int    err_idx;
    byte_t err_x;
    bit    stall;
    int    restart_at;
    bit    idle_valid;
    bit    exp_match;
  } vec_t;

  logic  clk;
  logic  rst;
  logic  start;
  byte_t c       [CB];
  byte_t k_prime [SB];
  byte_t k_bar   [SB];
  logic  busy;
  logic  done;
  logic  match;
  byte_t k_out   [SB];
  byte_t zero_k  [SB];

  kpke_ct_compare_select_if cp_if ();

  kpke_ct_compare_select dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .c       (c),
    .k_prime (k_prime),
    .k_bar   (k_bar),
    .cp      (cp_if.slave),
    .busy    (busy),
    .done    (done),
    .match   (match),
    .k_out   (k_out)
  );

  int n_chk = 0;
  int n_err = 0;
  int edge_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic check_key(input string nm, input byte_t exp [SB]);
    int bad;
    bad = -1;
    n_chk++;
    for (int i = SB - 1; i >= 0; i--) begin
      if (k_out[i] !== exp[i]) bad = i;
    end
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: k_out[%0d] got %0h want %0h",
               nm, bad, k_out[bad], exp[bad]);
    end
  endtask

  task automatic run_vec(input vec_t tv, output int lat, output int gap,
                         output int beats, output bit to);
    byte_t cpd [CB];
    int bidx, start_edge, last_edge, done_edge, extra, n;
    bit tog, vld, restarted;
    for (int i = 0; i < CB; i++) cpd[i] = c[i];
    if (tv.err_idx >= 0) cpd[tv.err_idx] = cpd[tv.err_idx] ^ tv.err_x;
    if (tv.idle_valid) begin
      repeat (3) begin
        @(negedge clk);
        check({tv.name, ".idle_ready"}, 32'(cp_if.cp_ready), 0);
        cp_if.cp_valid = 1'b1;
        cp_if.cp_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b1;
    cp_if.cp_valid = 1'b0;
    start_edge = edge_cnt + 1;
    bidx = 0; last_edge = -100; done_edge = -1;
    extra = 0; n = 0; beats = 0; tog = 1'b1; restarted = 1'b0;
    while (n < 6000 && done_edge < 0) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 1) begin
        check({tv.name, ".clr_match"}, 32'(match), 0);
        check_key({tv.name, ".clr_key"}, zero_k);
      end
      if (done) begin
        done_edge = edge_cnt + 1;
        cp_if.cp_valid = 1'b0;
      end else begin
        if (bidx >= CB) vld = 1'b0;
        else if (tv.stall) begin
          if (extra < 200 && $urandom_range(0, 7) == 0) begin
            vld = 1'b0;
            extra++;
          end else begin
            vld = tog;
            tog = ~tog;
          end
        end else vld = 1'b1;
        cp_if.cp_valid = vld;
        cp_if.cp_data  = (vld && bidx < CB) ? cpd[bidx] : 8'($urandom);
        if (vld && cp_if.cp_ready) begin
          beats++;
          bidx++;
          last_edge = edge_cnt + 1;
        end
        if (tv.restart_at >= 0 && bidx == tv.restart_at && !restarted) begin
          start = 1'b1;
          restarted = 1'b1;
        end
      end
    end
    to  = (done_edge < 0);
    lat = done_edge - start_edge;
    gap = done_edge - last_edge;
  endtask

  vec_t tbl [5];

  initial begin
    int lat, gap, beats;
    bit to;
    vec_t eqv;

    rst = 1'b1;
    start = 1'b0;
    cp_if.cp_valid = 1'b0;
    cp_if.cp_data  = '0;
    for (int i = 0; i < CB; i++) c[i] = 8'($urandom);
    for (int i = 0; i < SB; i++) begin
      k_prime[i] = 8'($urandom);
      k_bar[i]   = k_prime[i] ^ 8'(1 + (i % 255));
      zero_k[i]  = '0;
    end

    tbl[0] = '{"equal",     -1,    8'h00, 1'b0, -1, 1'b0, 1'b1};
    tbl[1] = '{"last_flip", CB-1,  8'h01, 1'b0, -1, 1'b0, 1'b0};
    tbl[2] = '{"first_flip", 0,    8'h80, 1'b0, -1, 1'b0, 1'b0};
    tbl[3] = '{"stall",     -1,    8'h00, 1'b1, -1, 1'b0, 1'b1};
    tbl[4] = '{"restart",   -1,    8'h00, 1'b0, 10, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    check("rst.busy",  32'(busy), 0);
    check("rst.done",  32'(done), 0);
    check("rst.match", 32'(match), 0);
    check("rst.ready", 32'(cp_if.cp_ready), 0);
    check_key("rst.key", zero_k);
    rst = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run_vec(tbl[t], lat, gap, beats, to);
      check({tbl[t].name, ".done_seen"}, 32'(!to), 1);
      check({tbl[t].name, ".match"}, 32'(match), 32'(tbl[t].exp_match));
      if (tbl[t].exp_match) check_key({tbl[t].name, ".key"}, k_prime);
      else                  check_key({tbl[t].name, ".key"}, k_bar);
      check({tbl[t].name, ".beats"}, 32'(beats), CB);
      check({tbl[t].name, ".gap"}, 32'(gap), 2);
      if (!tbl[t].stall) check({tbl[t].name, ".latency"}, 32'(lat), CB + 2);
      @(negedge clk);
      check({tbl[t].name, ".done_pulse"}, 32'(done), 0);
      check({tbl[t].name, ".hold_match"}, 32'(match),
            32'(tbl[t].exp_match));
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 500; b++) begin
      cp_if.cp_valid = 1'b1;
      cp_if.cp_data  = c[b];
      @(negedge clk);
    end
    check("mid.busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst.busy",  32'(busy), 0);
    check("arst.ready", 32'(cp_if.cp_ready), 0);
    check("arst.done",  32'(done), 0);
    check("arst.match", 32'(match), 0);
    check_key("arst.key", zero_k);
    cp_if.cp_valid = 1'b0;
    @(negedge clk);
    check("arst.hold", 32'(busy), 0);
    rst = 1'b0;
    eqv = '{"after_rst", -1, 8'h00, 1'b0, -1, 1'b0, 1'b1};
    run_vec(eqv, lat, gap, beats, to);
    check("after_rst.done_seen", 32'(!to), 1);
    check("after_rst.match", 32'(match), 1);
    check_key("after_rst.key", k_prime);
    check("after_rst.latency", 32'(lat), CB + 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
